// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin sharing of one MII TX MAC nibble port among N packet
// sources. A grant is locked for a whole packet. The MAC ack is routed back only
// to the granted source. If the granted source underruns, the frame is aborted.
module tx_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk_tx,
    input  logic           rst,
    input  logic [N-1:0]   req_vld,
    input  logic [N-1:0]   req_eof,
    input  logic [4*N-1:0] req_dat,
    output logic [N-1:0]   req_ack,
    output logic           mac_tx_vld,
    output logic           mac_tx_eof,
    output logic [3:0]     mac_tx_dat,
    input  logic           mac_tx_ack,
    output logic           grant_vld,
    output logic [IW-1:0]  grant_idx,
    output logic           pkt_done,
    output logic           underrun
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   grant_idx_q, grant_idx_d;
    logic [IW-1:0]   last_q, last_d;
    logic            pkt_done_q, pkt_done_d;
    logic            underrun_q, underrun_d;

    logic            busy;
    logic            sel_vld;
    logic            sel_eof;
    logic [3:0]      sel_dat;
    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   cand;
    logic            done_evt;
    logic            abort_evt;

    assign busy = (state_q == BUSY);

    // Select the request lines of the currently locked source.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sel_vld = 1'b0;
        sel_eof = 1'b0;
        sel_dat = 4'h0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx_q == IW'(i)) begin
                sel_vld = req_vld[i];
                sel_eof = req_eof[i];
                sel_dat = req_dat[4*i +: 4];
            end
        end
    end

    // Round-robin search starting just after the last winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(last_q) + k) % N);
            if (!win_found && req_vld[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign done_evt  = busy & mac_tx_ack & sel_vld & sel_eof;
    assign abort_evt = busy & mac_tx_ack & ~sel_vld;

    // MAC-side outputs and the ack steering back to the granted source only.
    always_comb begin
        req_ack = '0;
        for (int i = 0; i < N; i++) begin
            req_ack[i] = busy & (grant_idx_q == IW'(i)) & mac_tx_ack;
        end
    end

    assign mac_tx_vld = busy & sel_vld;
    assign mac_tx_dat = busy ? sel_dat : 4'h0;
    // Terminate the MAC's data state whenever nobody is validly driving it.
    assign mac_tx_eof = ~busy | rst | ~sel_vld | sel_eof;

    // Next-state logic: arbitrate in IDLE, release on done or abort in BUSY.
    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        last_d      = last_q;
        pkt_done_d  = 1'b0;
        underrun_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d     = BUSY;
                    grant_idx_d = win_idx;
                    last_d      = win_idx;
                end
            end
            BUSY: begin
                if (done_evt) begin
                    state_d    = IDLE;
                    pkt_done_d = 1'b1;
                end else if (abort_evt) begin
                    state_d    = IDLE;
                    underrun_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset; pointer resets so source 0 wins first.
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk_tx) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_idx_q <= '0;
            last_q      <= IW'(N - 1);
            pkt_done_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            last_q      <= last_d;
            pkt_done_q  <= pkt_done_d;
            underrun_q  <= underrun_d;
        end
    end

    assign grant_vld = busy;
    assign grant_idx = grant_idx_q;
    assign pkt_done  = pkt_done_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: directed scenarios for tx_arbiter with N=4, driving simple
// packet sources and a MAC that acks 16 cycles after the first valid nibble.
module tb_tx_arbiter;

    localparam int N       = 4;
    localparam int IW      = 2;
    localparam int ACK_DLY = 16;

    logic           clk_tx = 1'b0;
    logic           rst;
    logic [N-1:0]   req_vld, req_eof, req_ack;
    logic [4*N-1:0] req_dat;
    logic           mac_tx_vld, mac_tx_eof, mac_tx_ack;
    logic [3:0]     mac_tx_dat;
    logic           grant_vld;
    logic [IW-1:0]  grant_idx;
    logic           pkt_done, underrun;

    tx_arbiter #(.N(N), .IW(IW)) dut (
        .clk_tx     (clk_tx),
        .rst        (rst),
        .req_vld    (req_vld),
        .req_eof    (req_eof),
        .req_dat    (req_dat),
        .req_ack    (req_ack),
        .mac_tx_vld (mac_tx_vld),
        .mac_tx_eof (mac_tx_eof),
        .mac_tx_dat (mac_tx_dat),
        .mac_tx_ack (mac_tx_ack),
        .grant_vld  (grant_vld),
        .grant_idx  (grant_idx),
        .pkt_done   (pkt_done),
        .underrun   (underrun)
    );

    always #20 clk_tx = ~clk_tx;

    int tests = 0;
    int fails = 0;

    // Source models
    int         pkt_len[N], pos[N], pkts_left[N], drop_pos[N];
    logic [3:0] pkt_base[N];
    logic [N-1:0] force_low, pulse_hi;
    // MAC model
    bit mac_busy;
    int mac_cnt;
    // Observation logs
    int cyc = 0;
    int grant_log[$], grant_cyc[$], done_cyc[$], eof_cyc[$], abort_cyc[$], under_cyc[$];
    logic [3:0] dat_log[$];
    int abort_eof[$];
    int bad_ack, overlap, gv_at_pulse;
    bit prev_gv = 1'b0;
    logic last_eof, last_gv;
    logic [IW-1:0] last_gidx;

    function automatic int qget(int q[$], int k);
        return (k < q.size()) ? q[k] : -1;
    endfunction

    // One clock cycle: drive inputs, sample at negedge, update models after the edge.
    task automatic cycle();
        logic [N-1:0] vld_s, ack_s, eof_s;
        logic mvld_s, meof_s, mack_s;
        for (int i = 0; i < N; i++) begin
            req_vld[i] = ((pkts_left[i] > 0) && !(drop_pos[i] >= 0 && pos[i] >= drop_pos[i])
                          && !force_low[i]) || pulse_hi[i];
            req_dat[4*i +: 4] = pkt_base[i] + 4'(pos[i]);
            req_eof[i] = (pos[i] == pkt_len[i] - 1);
        end
        mac_tx_ack = mac_busy && (mac_cnt >= ACK_DLY);
        @(negedge clk_tx);
        vld_s = req_vld; ack_s = req_ack; eof_s = req_eof;
        mvld_s = mac_tx_vld; meof_s = mac_tx_eof; mack_s = mac_tx_ack;
        last_eof = mac_tx_eof; last_gv = grant_vld; last_gidx = grant_idx;
        for (int i = 0; i < N; i++)
            if (req_ack[i] && !(grant_vld && grant_idx == IW'(i))) bad_ack++;
        if (grant_vld && !prev_gv) begin
            grant_log.push_back(int'(grant_idx));
            grant_cyc.push_back(cyc);
        end
        prev_gv = grant_vld;
        if (mac_tx_ack && mac_tx_vld) dat_log.push_back(mac_tx_dat);
        if (mac_tx_ack && mac_tx_vld && mac_tx_eof) eof_cyc.push_back(cyc);
        if (mac_tx_ack && grant_vld && !mac_tx_vld) begin
            abort_cyc.push_back(cyc);
            abort_eof.push_back(int'(mac_tx_eof));
        end
        if (pkt_done) done_cyc.push_back(cyc);
        if (underrun) under_cyc.push_back(cyc);
        if (pkt_done && underrun) overlap++;
        if ((pkt_done || underrun) && grant_vld) gv_at_pulse++;
        @(posedge clk_tx);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (vld_s[i] && ack_s[i]) begin
                if (eof_s[i]) begin
                    pkts_left[i]--;
                    pos[i] = 0;
                end else begin
                    pos[i]++;
                end
            end
        end
        if (mac_busy && mack_s && meof_s) begin
            mac_busy = 1'b0;
            mac_cnt  = 0;
        end else if (mac_busy) begin
            mac_cnt++;
        end else if (mvld_s) begin
            mac_busy = 1'b1;
            mac_cnt  = 1;
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) begin
            pkt_len[i] = 1; pos[i] = 0; pkts_left[i] = 0; drop_pos[i] = -1; pkt_base[i] = 4'h0;
        end
        force_low = '0; pulse_hi = '0; mac_busy = 1'b0; mac_cnt = 0;
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        grant_log.delete(); grant_cyc.delete(); done_cyc.delete(); eof_cyc.delete();
        abort_cyc.delete(); under_cyc.delete(); dat_log.delete(); abort_eof.delete();
        bad_ack = 0; overlap = 0; gv_at_pulse = 0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (grant_vld !== 1'b0) begin fails++; $display("FAIL reset_grant_vld: got %b want 0", grant_vld); end
        tests++; if (grant_idx !== 2'd0) begin fails++; $display("FAIL reset_grant_idx: got %0d want 0", grant_idx); end
        tests++; if (pkt_done !== 1'b0 || underrun !== 1'b0) begin fails++; $display("FAIL reset_pulses: got done=%b und=%b want 0 0", pkt_done, underrun); end
        tests++; if (mac_tx_vld !== 1'b0 || mac_tx_dat !== 4'h0) begin fails++; $display("FAIL reset_mac_out: got vld=%b dat=%h want 0 0", mac_tx_vld, mac_tx_dat); end
        tests++; if (mac_tx_eof !== 1'b1) begin fails++; $display("FAIL reset_eof: got %b want 1", mac_tx_eof); end
        tests++; if (req_ack !== 4'b0000) begin fails++; $display("FAIL reset_req_ack: got %b want 0000", req_ack); end
        cycle();
        tests++; if (last_gv !== 1'b0) begin fails++; $display("FAIL idle_no_req: grant_vld got %b want 0", last_gv); end
    endtask

    task automatic test_single();
        int c0;
        do_reset();
        pkt_len[0] = 8; pkts_left[0] = 1; pkt_base[0] = 4'h0;
        c0 = cyc;
        for (int k = 0; k < 200 && done_cyc.size() < 1; k++) cycle();
        tests++; if (done_cyc.size() != 1) begin fails++; $display("FAIL single_done_count: got %0d want 1", done_cyc.size()); end
        tests++; if (grant_log.size() != 1 || qget(grant_log, 0) != 0) begin fails++; $display("FAIL single_grant: got n=%0d idx=%0d want 1 grant to 0", grant_log.size(), qget(grant_log, 0)); end
        tests++; if (qget(grant_cyc, 0) != c0 + 1) begin fails++; $display("FAIL single_latency: grant at %0d want %0d", qget(grant_cyc, 0), c0 + 1); end
        tests++; if (dat_log.size() != 8) begin fails++; $display("FAIL single_nibbles: got %0d want 8", dat_log.size()); end
        for (int k = 0; k < 8 && k < dat_log.size(); k++) begin
            tests++; if (dat_log[k] !== 4'(k)) begin fails++; $display("FAIL single_dat%0d: got %h want %h", k, dat_log[k], 4'(k)); end
        end
        tests++; if (eof_cyc.size() != 1) begin fails++; $display("FAIL single_eof_count: got %0d want 1", eof_cyc.size()); end
        tests++; if (qget(done_cyc, 0) != qget(eof_cyc, 0) + 1) begin fails++; $display("FAIL single_done_timing: got %0d want %0d", qget(done_cyc, 0), qget(eof_cyc, 0) + 1); end
        tests++; if (gv_at_pulse != 0 || under_cyc.size() != 0 || bad_ack != 0) begin fails++; $display("FAIL single_clean: got gv_at_pulse=%0d und=%0d bad_ack=%0d want 0 0 0", gv_at_pulse, under_cyc.size(), bad_ack); end
        cycle();
        tests++; if (last_gv !== 1'b0) begin fails++; $display("FAIL single_idle_after: grant_vld got %b want 0", last_gv); end
    endtask

    task automatic test_two_sources();
        logic [3:0] exp_dat[12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h8, 4'h9, 4'hA, 4'hB, 4'h0, 4'h1, 4'h2, 4'h3};
        do_reset();
        pkt_len[0] = 4; pkts_left[0] = 2; pkt_base[0] = 4'h0;
        pkt_len[2] = 4; pkts_left[2] = 1; pkt_base[2] = 4'h8;
        for (int k = 0; k < 400 && done_cyc.size() < 3; k++) cycle();
        tests++; if (done_cyc.size() != 3) begin fails++; $display("FAIL two_done_count: got %0d want 3", done_cyc.size()); end
        tests++; if (qget(grant_log, 0) != 0 || qget(grant_log, 1) != 2 || qget(grant_log, 2) != 0) begin fails++; $display("FAIL two_order: got %0d,%0d,%0d want 0,2,0", qget(grant_log, 0), qget(grant_log, 1), qget(grant_log, 2)); end
        tests++; if (qget(grant_cyc, 1) != qget(done_cyc, 0) + 1) begin fails++; $display("FAIL two_regrant1: got %0d want %0d", qget(grant_cyc, 1), qget(done_cyc, 0) + 1); end
        tests++; if (qget(grant_cyc, 2) != qget(done_cyc, 1) + 1) begin fails++; $display("FAIL two_regrant2: got %0d want %0d", qget(grant_cyc, 2), qget(done_cyc, 1) + 1); end
        tests++; if (dat_log.size() != 12) begin fails++; $display("FAIL two_nibbles: got %0d want 12", dat_log.size()); end
        for (int k = 0; k < 12 && k < dat_log.size(); k++) begin
            tests++; if (dat_log[k] !== exp_dat[k]) begin fails++; $display("FAIL two_dat%0d: got %h want %h", k, dat_log[k], exp_dat[k]); end
        end
        tests++; if (bad_ack != 0) begin fails++; $display("FAIL two_bad_ack: got %0d want 0", bad_ack); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < N; i++) begin
            pkt_len[i] = 2; pkts_left[i] = 4; pkt_base[i] = 4'(4 * i);
        end
        for (int k = 0; k < 2000 && done_cyc.size() < 16; k++) cycle();
        tests++; if (done_cyc.size() != 16) begin fails++; $display("FAIL rr_done_count: got %0d want 16", done_cyc.size()); end
        for (int k = 0; k < 16; k++) begin
            tests++; if (qget(grant_log, k) != k % 4) begin fails++; $display("FAIL rr_grant%0d: got %0d want %0d", k, qget(grant_log, k), k % 4); end
        end
        tests++; if (bad_ack != 0) begin fails++; $display("FAIL rr_bad_ack: got %0d want 0", bad_ack); end
        tests++; if (overlap != 0 || under_cyc.size() != 0) begin fails++; $display("FAIL rr_pulses: got overlap=%0d und=%0d want 0 0", overlap, under_cyc.size()); end
        tests++; if (dat_log.size() != 32) begin fails++; $display("FAIL rr_nibbles: got %0d want 32", dat_log.size()); end
    endtask

    task automatic test_underrun();
        do_reset();
        pkt_len[1] = 8; pkts_left[1] = 1; pkt_base[1] = 4'h3; drop_pos[1] = 3;
        for (int k = 0; k < 200 && under_cyc.size() < 1; k++) cycle();
        tests++; if (under_cyc.size() != 1) begin fails++; $display("FAIL und_count: got %0d want 1", under_cyc.size()); end
        tests++; if (grant_log.size() != 1 || qget(grant_log, 0) != 1) begin fails++; $display("FAIL und_grant: got n=%0d idx=%0d want 1 grant to 1", grant_log.size(), qget(grant_log, 0)); end
        tests++; if (abort_cyc.size() != 1 || qget(abort_eof, 0) != 1) begin fails++; $display("FAIL und_abort_eof: got n=%0d eof=%0d want 1 1", abort_cyc.size(), qget(abort_eof, 0)); end
        tests++; if (qget(under_cyc, 0) != qget(abort_cyc, 0) + 1) begin fails++; $display("FAIL und_timing: got %0d want %0d", qget(under_cyc, 0), qget(abort_cyc, 0) + 1); end
        tests++; if (dat_log.size() != 3 || dat_log[0] !== 4'h3 || dat_log[2] !== 4'h5) begin fails++; $display("FAIL und_nibbles: got n=%0d want 3 nibbles 3..5", dat_log.size()); end
        tests++; if (done_cyc.size() != 0 || gv_at_pulse != 0) begin fails++; $display("FAIL und_no_done: got done=%0d gv=%0d want 0 0", done_cyc.size(), gv_at_pulse); end
        cycle();
        tests++; if (last_gv !== 1'b0) begin fails++; $display("FAIL und_idle: grant_vld got %b want 0", last_gv); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        pkt_len[0] = 8; pkts_left[0] = 1; pkt_base[0] = 4'h0;
        for (int k = 0; k < 100 && dat_log.size() < 2; k++) cycle();
        tests++; if (dat_log.size() != 2 || last_eof !== 1'b0) begin fails++; $display("FAIL rmid_pre: got n=%0d eof=%b want 2 0", dat_log.size(), last_eof); end
        pkt_len[1] = 2; pkts_left[1] = 1; pkt_base[1] = 4'hC;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        tests++; if (last_eof !== 1'b1) begin fails++; $display("FAIL rmid_eof: got %b want 1", last_eof); end
        cycle();
        tests++; if (last_gv !== 1'b0) begin fails++; $display("FAIL rmid_drop: grant_vld got %b want 0", last_gv); end
        cycle();
        tests++; if (last_gv !== 1'b1 || last_gidx !== 2'd0) begin fails++; $display("FAIL rmid_tie: got vld=%b idx=%0d want 1 0", last_gv, last_gidx); end
    endtask

    task automatic test_hold();
        int viol = 0;
        logic [3:0] exp_dat[4] = '{4'h5, 4'h6, 4'h7, 4'h8};
        do_reset();
        pkt_len[0] = 4; pkts_left[0] = 1; pkt_base[0] = 4'h5;
        cycle();
        cycle();
        for (int k = 0; k < 10; k++) begin
            pulse_hi[1] = (k == 2 || k == 6);
            force_low[0] = (k == 4 || k == 5);
            cycle();
            if (last_gv !== 1'b1 || last_gidx !== 2'd0) viol++;
        end
        pulse_hi = '0; force_low = '0;
        tests++; if (viol != 0) begin fails++; $display("FAIL hold_locked: got %0d unlocked cycles want 0", viol); end
        tests++; if (bad_ack != 0) begin fails++; $display("FAIL hold_bad_ack: got %0d want 0", bad_ack); end
        tests++; if (under_cyc.size() != 0) begin fails++; $display("FAIL hold_early_drop: underruns got %0d want 0", under_cyc.size()); end
        for (int k = 0; k < 200 && done_cyc.size() < 1; k++) cycle();
        tests++; if (done_cyc.size() != 1 || grant_log.size() != 1) begin fails++; $display("FAIL hold_done: got done=%0d grants=%0d want 1 1", done_cyc.size(), grant_log.size()); end
        tests++; if (dat_log.size() != 4) begin fails++; $display("FAIL hold_nibbles: got %0d want 4", dat_log.size()); end
        for (int k = 0; k < 4 && k < dat_log.size(); k++) begin
            tests++; if (dat_log[k] !== exp_dat[k]) begin fails++; $display("FAIL hold_dat%0d: got %h want %h", k, dat_log[k], exp_dat[k]); end
        end
    endtask

    initial begin
        rst = 1'b1; mac_tx_ack = 1'b0;
        req_vld = '0; req_eof = '0; req_dat = '0;
        test_reset();
        test_single();
        test_two_sources();
        test_round_robin();
        test_underrun();
        test_reset_mid();
        test_hold();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
